apb_uart_fifo: RTL

Parametrised APB-attached UART, the buffered successor to the single-register APB UART. The block presents a small register map on an APB slave port, queues transmit and receive bytes in depth-configurable FIFOs, and serialises and deserialises 8-bit frames with a programmable bit period, optional parity and one or two stop bits. Sticky error flags and a maskable level interrupt are included. It sits between the APB interconnect and the chip's TX/RX pins.

---
 rtl/apb_uart_fifo_pkg.sv | 25 ++
 rtl/uart_sync_fifo.sv | 42 ++++
 rtl/apb_uart_fifo.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_uart_fifo_pkg.sv
// apb_uart_fifo_pkg: register offsets, bit indices and FSM states for apb_uart_fifo
package apb_uart_fifo_pkg;
  localparam int unsigned OFF_TXDATA = 'h00;
  localparam int unsigned OFF_RXDATA = 'h04;
  localparam int unsigned OFF_STATUS = 'h08;
  localparam int unsigned OFF_CTRL = 'h0C;
  localparam int unsigned OFF_DIV = 'h10;
  localparam int unsigned OFF_IRQ_EN = 'h14;
  localparam int unsigned ST_TX_EMPTY = 0;
  localparam int unsigned ST_TX_FULL = 1;
  localparam int unsigned ST_RX_EMPTY = 2;
  localparam int unsigned ST_RX_FULL = 3;
  localparam int unsigned ST_TX_BUSY = 4;
  localparam int unsigned ST_OVERRUN = 5;
  localparam int unsigned ST_FRAME_ERR = 6;
  localparam int unsigned ST_PARITY_ERR = 7;
  localparam int unsigned CT_TX_EN = 0;
  localparam int unsigned CT_RX_EN = 1;
  localparam int unsigned CT_PAR_EN = 2;
  localparam int unsigned CT_PAR_ODD = 3;
  localparam int unsigned CT_TWO_STOP = 4;
  localparam logic [4:0] CTRL_RESET = 5'h03;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous FIFO with wrap-bit pointers; push on full succeeds when a pop coincides
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic do_push, do_pop;
  assign empty = wr_q == rd_q;
  assign full = wr_q == {~rd_q[AW], rd_q[AW-1:0]};
  assign count = wr_q - rd_q;
  assign dout = mem_q[rd_q[AW-1:0]];
  always_comb begin
    do_pop = pop & ~empty;
    do_push = push & (~full | do_pop);
    wr_d = wr_q + {{AW{1'b0}}, do_push};
    rd_d = rd_q + {{AW{1'b0}}, do_pop};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/apb_uart_fifo.sv
// apb_uart_fifo: APB UART with TX/RX FIFOs, programmable divisor, parity, sticky errors and irq
module apb_uart_fifo import apb_uart_fifo_pkg::*; #(
  parameter int APB_DATA_WIDTH = 32,
  parameter int APB_ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH = 16,
  parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = 16'd868
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic                      PSELx,
  input  logic                      PENABLE,
  input  logic                      PWRITE,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [APB_DATA_WIDTH-1:0] PWDATA,
  output logic [APB_DATA_WIDTH-1:0] PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic                      RX,
  output logic                      Tx,
  output logic                      irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic acc, sel_tx, sel_rx, sel_st, sel_ctrl, sel_div, sel_ien, bad, wr_ok, rd_ok;
  logic tx_push, tx_pop, tx_full, tx_empty, rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] tx_dout, rx_dout, status, ien_q, ien_d;
  logic [CW-1:0] tx_level, rx_level;
  logic [APB_DATA_WIDTH-1:0] rdata;
  logic [4:0] ctrl_q, ctrl_d;
  logic [DIV_WIDTH-1:0] div_q, div_d, wdiv;
  logic [2:0] err_q, err_d, err_ev;
  logic irq_q, irq_d;
  tx_state_e tx_st_q, tx_st_d;
  logic [DIV_WIDTH-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic tx_par_q, tx_par_d, tx_pen_q, tx_pen_d, tx_two_q, tx_two_d, tx_stp_q, tx_stp_d, tx_q, tx_d, tx_tick;
  rx_state_e rx_st_q, rx_st_d;
  logic [2:0] rx_sync_q, rx_sync_d;
  logic [DIV_WIDTH-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic rx_pen_q, rx_pen_d, rx_podd_q, rx_podd_d, rx_perr_q, rx_perr_d, rx_tick, rx_s2, rx_prev;
  logic unused_levels;
  assign unused_levels = ^{tx_level, rx_level, PWDATA};
  assign Tx = tx_q;
  assign irq = irq_q;
  assign rx_s2 = rx_sync_q[1];
  assign rx_prev = rx_sync_q[2];
  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(PCLK), .rst_n(PRESETn), .push(tx_push), .pop(tx_pop), .din(PWDATA[7:0]),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_level)
  );
  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(PCLK), .rst_n(PRESETn), .push(rx_push), .pop(rx_pop), .din(rx_sh_q),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_level)
  );
  always_comb begin
    acc = PSELx & PENABLE;
    sel_tx = PADDR == APB_ADDR_WIDTH'(OFF_TXDATA);
    sel_rx = PADDR == APB_ADDR_WIDTH'(OFF_RXDATA);
    sel_st = PADDR == APB_ADDR_WIDTH'(OFF_STATUS);
    sel_ctrl = PADDR == APB_ADDR_WIDTH'(OFF_CTRL);
    sel_div = PADDR == APB_ADDR_WIDTH'(OFF_DIV);
    sel_ien = PADDR == APB_ADDR_WIDTH'(OFF_IRQ_EN);
    bad = ~(sel_tx | sel_rx | sel_st | sel_ctrl | sel_div | sel_ien) |
          (PWRITE ? (sel_rx | (sel_tx & tx_full & ~tx_pop)) : (sel_tx | (sel_rx & rx_empty)));
    wr_ok = acc & PWRITE & ~bad;
    rd_ok = acc & ~PWRITE & ~bad;
    tx_push = wr_ok & sel_tx;
    rx_pop = rd_ok & sel_rx;
    status = '0;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_TX_FULL] = tx_full;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_RX_FULL] = rx_full;
    status[ST_TX_BUSY] = tx_st_q != TX_IDLE;
    status[ST_OVERRUN] = err_q[0];
    status[ST_FRAME_ERR] = err_q[1];
    status[ST_PARITY_ERR] = err_q[2];
    rdata = sel_rx ? APB_DATA_WIDTH'(rx_dout) :
            sel_st ? APB_DATA_WIDTH'(status) :
            sel_ctrl ? APB_DATA_WIDTH'(ctrl_q) :
            sel_div ? APB_DATA_WIDTH'(div_q) :
            sel_ien ? APB_DATA_WIDTH'(ien_q) : '0;
    PREADY = acc;
    PSLVERR = acc & bad;
    PRDATA = rd_ok ? rdata : '0;
    wdiv = PWDATA[DIV_WIDTH-1:0];
    ctrl_d = (wr_ok & sel_ctrl) ? PWDATA[4:0] : ctrl_q;
    div_d = (wr_ok & sel_div) ? ((wdiv < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : wdiv) : div_q;
    ien_d = (wr_ok & sel_ien) ? PWDATA[7:0] : ien_q;
    err_d = (err_q & ~((wr_ok & sel_st) ? PWDATA[ST_PARITY_ERR:ST_OVERRUN] : 3'b0)) | err_ev;
    irq_d = |(status & ien_q);
  end
  always_comb begin
    tx_st_d = tx_st_q;
    tx_cnt_d = tx_cnt_q + DIV_WIDTH'(1);
    tx_div_d = tx_div_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d = tx_sh_q;
    tx_par_d = tx_par_q;
    tx_pen_d = tx_pen_q;
    tx_two_d = tx_two_q;
    tx_stp_d = tx_stp_q;
    tx_d = tx_q;
    tx_pop = 1'b0;
    tx_tick = tx_cnt_q == tx_div_q - DIV_WIDTH'(1);
    unique case (tx_st_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        tx_d = 1'b1;
        if (ctrl_q[CT_TX_EN] && !tx_empty) begin
          tx_pop = 1'b1;
          tx_st_d = TX_START;
          tx_sh_d = tx_dout;
          tx_div_d = div_q;
          tx_par_d = ^tx_dout ^ ctrl_q[CT_PAR_ODD];
          tx_pen_d = ctrl_q[CT_PAR_EN];
          tx_two_d = ctrl_q[CT_TWO_STOP];
          tx_d = 1'b0;
        end
      end
      TX_START: if (tx_tick) begin
        tx_cnt_d = '0;
        tx_bit_d = '0;
        tx_st_d = TX_DATA;
        tx_d = tx_sh_q[0];
      end
      TX_DATA: if (tx_tick) begin
        tx_cnt_d = '0;
        tx_bit_d = tx_bit_q + 3'd1;
        tx_sh_d = tx_sh_q >> 1;
        tx_d = tx_sh_q[1];
        if (tx_bit_q == 3'd7) begin
          tx_st_d = tx_pen_q ? TX_PARITY : TX_STOP;
          tx_d = tx_pen_q ? tx_par_q : 1'b1;
          tx_stp_d = 1'b0;
        end
      end
      TX_PARITY: if (tx_tick) begin
        tx_cnt_d = '0;
        tx_st_d = TX_STOP;
        tx_stp_d = 1'b0;
        tx_d = 1'b1;
      end
      TX_STOP: if (tx_tick) begin
        tx_cnt_d = '0;
        tx_stp_d = 1'b1;
        tx_st_d = (tx_two_q && !tx_stp_q) ? TX_STOP : TX_IDLE;
      end
      default: tx_st_d = TX_IDLE;
    endcase
  end
  always_comb begin
    rx_sync_d = {rx_sync_q[1:0], RX};
    rx_st_d = rx_st_q;
    rx_cnt_d = rx_cnt_q + DIV_WIDTH'(1);
    rx_div_d = rx_div_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d = rx_sh_q;
    rx_pen_d = rx_pen_q;
    rx_podd_d = rx_podd_q;
    rx_perr_d = rx_perr_q;
    rx_push = 1'b0;
    err_ev = '0;
    rx_tick = rx_cnt_q == rx_div_q - DIV_WIDTH'(1);
    unique case (rx_st_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (ctrl_q[CT_RX_EN] && rx_prev && !rx_s2) begin
          rx_st_d = RX_START;
          rx_div_d = div_q;
          rx_pen_d = ctrl_q[CT_PAR_EN];
          rx_podd_d = ctrl_q[CT_PAR_ODD];
          rx_perr_d = 1'b0;
        end
      end
      RX_START: if (rx_cnt_q == (rx_div_q >> 1) - DIV_WIDTH'(1)) begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        rx_st_d = rx_s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_tick) begin
        rx_cnt_d = '0;
        rx_sh_d = {rx_s2, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_st_d = rx_pen_q ? RX_PARITY : RX_STOP;
      end
      RX_PARITY: if (rx_tick) begin
        rx_cnt_d = '0;
        rx_perr_d = ^{rx_sh_q, rx_s2, rx_podd_q};
        rx_st_d = RX_STOP;
      end
      RX_STOP: if (rx_tick) begin
        rx_cnt_d = '0;
        rx_st_d = RX_IDLE;
        rx_push = rx_s2 & (~rx_full | rx_pop);
        err_ev = rx_s2 ? {rx_perr_q, 1'b0, rx_full & ~rx_pop} : 3'b010;
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      ctrl_q <= CTRL_RESET;
      div_q <= DEFAULT_DIV;
      ien_q <= '0;
      err_q <= '0;
      irq_q <= 1'b0;
      tx_st_q <= TX_IDLE;
      tx_cnt_q <= '0;
      tx_div_q <= DEFAULT_DIV;
      tx_bit_q <= '0;
      tx_sh_q <= '0;
      tx_par_q <= 1'b0;
      tx_pen_q <= 1'b0;
      tx_two_q <= 1'b0;
      tx_stp_q <= 1'b0;
      tx_q <= 1'b1;
      rx_st_q <= RX_IDLE;
      rx_sync_q <= 3'b111;
      rx_cnt_q <= '0;
      rx_div_q <= DEFAULT_DIV;
      rx_bit_q <= '0;
      rx_sh_q <= '0;
      rx_pen_q <= 1'b0;
      rx_podd_q <= 1'b0;
      rx_perr_q <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      div_q <= div_d;
      ien_q <= ien_d;
      err_q <= err_d;
      irq_q <= irq_d;
      tx_st_q <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_div_q <= tx_div_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q <= tx_sh_d;
      tx_par_q <= tx_par_d;
      tx_pen_q <= tx_pen_d;
      tx_two_q <= tx_two_d;
      tx_stp_q <= tx_stp_d;
      tx_q <= tx_d;
      rx_st_q <= rx_st_d;
      rx_sync_q <= rx_sync_d;
      rx_cnt_q <= rx_cnt_d;
      rx_div_q <= rx_div_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q <= rx_sh_d;
      rx_pen_q <= rx_pen_d;
      rx_podd_q <= rx_podd_d;
      rx_perr_q <= rx_perr_d;
    end
  end
endmodule
